// File: rtl/emu_clk_pkg.sv
// Shared types for the emulated clock generator and other timestep requesters.
// Holds the timestep type, its idle value and the oscillator state encoding.
package emu_clk_pkg;

   localparam int DT_WIDTH = 32;

   typedef logic [DT_WIDTH-1:0] dt_t;

   localparam dt_t DT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } clk_gen_state_t;

endpackage

// File: rtl/emu_dt_cmp.sv
// Compare a granted timestep against a requester's remaining count.
// Ports: emu_dt, remaining in; hit (edge due), over (grant overshot), next_remaining out.
module emu_dt_cmp #(
   parameter int W = 32
) (
   input  logic [W-1:0] emu_dt,
   input  logic [W-1:0] remaining,
   output logic         hit,
   output logic         over,
   output logic [W-1:0] next_remaining
);

   // A zero grant never reaches an edge, even if remaining were zero.
   always_comb begin
      hit            = (emu_dt != '0) && (emu_dt >= remaining);
      over           = emu_dt > remaining;
      next_remaining = hit ? remaining : remaining - emu_dt;
   end

endmodule

// File: rtl/emu_clk_gen.sv
// One emulated oscillator: requests a timestep to its next edge, consumes the grant.
// Ports: clk, rst_n, enable, half_period, emu_dt in; dt_req, clk_val, clk_rise, dt_err out.
module emu_clk_gen #(
   parameter int                  DT_WIDTH = 32,
   parameter logic [DT_WIDTH-1:0] DT_MAX   = {DT_WIDTH{1'b1}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [DT_WIDTH-1:0] half_period,
   input  logic [DT_WIDTH-1:0] emu_dt,
   output logic [DT_WIDTH-1:0] dt_req,
   output logic                clk_val,
   output logic                clk_rise,
   output logic                dt_err
);

   import emu_clk_pkg::*;

   localparam logic [DT_WIDTH-1:0] ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   clk_gen_state_t      state, state_n;
   logic [DT_WIDTH-1:0] remaining, rem_n;
   logic                val_n, rise_n, err_n;
   logic [DT_WIDTH-1:0] hp_eff;
   logic                hit, over;
   logic [DT_WIDTH-1:0] next_rem;

   emu_dt_cmp #(
      .W (DT_WIDTH)
   ) u_cmp (
      .emu_dt         (emu_dt),
      .remaining      (remaining),
      .hit            (hit),
      .over           (over),
      .next_remaining (next_rem)
   );

   assign hp_eff = (half_period == '0) ? ONE : half_period;
   assign dt_req = remaining;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= DT_MAX;
         clk_val   <= 1'b0;
         clk_rise  <= 1'b0;
         dt_err    <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= rem_n;
         clk_val   <= val_n;
         clk_rise  <= rise_n;
         dt_err    <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = remaining;
      val_n   = clk_val;
      rise_n  = 1'b0;
      err_n   = dt_err;
      unique case (state)
         IDLE: begin
            rem_n = DT_MAX;
            val_n = 1'b0;
            if (enable) begin
               state_n = RUN;
               rem_n   = hp_eff;
            end
         end
         RUN, STOP: begin
            if (over) err_n = 1'b1;
            if (!enable && !clk_val) begin
               // Low level: stop at once, dropping any coincident rise.
               state_n = IDLE;
               rem_n   = DT_MAX;
            end else begin
               // High level without enable drains to the falling edge.
               // Re-enabling while draining keeps the running count.
               state_n = enable ? RUN : STOP;
               rem_n   = next_rem;
               if (hit) begin
                  val_n  = ~clk_val;
                  rise_n = ~clk_val;
                  if (!enable) begin
                     state_n = IDLE;
                     rem_n   = DT_MAX;
                  end else begin
                     rem_n = hp_eff;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            rem_n   = DT_MAX;
            val_n   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_emu_clk_gen.sv
// Self-checking bench for emu_clk_gen against an absolute-time oscillator model.
// Ports exercised: all; directed scenarios plus a randomized run.
module tb_emu_clk_gen;

   localparam logic [31:0] DTM = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [31:0] half_period;
   logic [31:0] emu_dt;
   logic [31:0] dt_req;
   logic        clk_val;
   logic        clk_rise;
   logic        dt_err;

   int checks = 0;
   int errors = 0;

   // Model: absolute emulated time and time of the next scheduled edge.
   bit              m_act;
   bit              m_lvl;
   bit              m_rise;
   bit              m_err;
   longint unsigned m_now;
   longint unsigned m_edge;
   logic [31:0]     m_req;

   emu_clk_gen #(
      .DT_WIDTH (32),
      .DT_MAX   (DTM)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .half_period (half_period),
      .emu_dt      (emu_dt),
      .dt_req      (dt_req),
      .clk_val     (clk_val),
      .clk_rise    (clk_rise),
      .dt_err      (dt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_act  = 0;
      m_lvl  = 0;
      m_rise = 0;
      m_err  = 0;
      m_now  = 0;
      m_edge = 0;
      m_req  = DTM;
   endfunction

   function automatic void model_step(bit en, logic [31:0] hp, logic [31:0] dt);
      longint unsigned hpe;
      hpe    = (hp == 0) ? 64'd1 : 64'(hp);
      m_rise = 0;
      if (!m_act) begin
         if (en) begin
            m_act  = 1;
            m_now  = 0;
            m_edge = hpe;
         end
      end else begin
         if (64'(dt) > m_edge - m_now) m_err = 1;
         if (!en && !m_lvl) begin
            m_act = 0;
         end else begin
            m_now += 64'(dt);
            if (dt != 0 && m_now >= m_edge) begin
               m_lvl  = !m_lvl;
               m_rise = m_lvl;
               if (!en) m_act = 0;
               else m_edge = m_now + hpe;
            end
         end
      end
      m_req = m_act ? 32'(m_edge - m_now) : DTM;
   endfunction

   task automatic step(input bit en, input logic [31:0] hp, input logic [31:0] dt);
      enable      = en;
      half_period = hp;
      emu_dt      = dt;
      @(posedge clk);
      model_step(en, hp, dt);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      emu_dt = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dt_req !== DTM || clk_val !== 1'b0 || clk_rise !== 1'b0 || dt_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_vals: got req=%h val=%b rise=%b err=%b", dt_req, clk_val, clk_rise, dt_err);
      end
      step(0, 32'd5, 32'd1);
      checks++;
      if (dt_req !== DTM || clk_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got req=%h val=%b, want req=%h val=0", dt_req, clk_val, DTM);
      end
   endtask

   task automatic test_hp5();
      bit exp_val;
      bit exp_rise;
      do_reset();
      step(1, 32'd5, 32'd1);
      for (int k = 1; k <= 30; k++) begin
         step(1, 32'd5, 32'd1);
         exp_rise = (k % 10) == 5;
         exp_val  = ((k / 5) % 2) == 1;
         checks++;
         if (clk_rise !== exp_rise || clk_val !== exp_val) begin
            errors++;
            $display("FAIL hp5 k=%0d: got val=%b rise=%b, want val=%b rise=%b", k, clk_val, clk_rise, exp_val, exp_rise);
         end
      end
   endtask

   task automatic test_grants();
      do_reset();
      step(1, 32'd10, 32'd0);
      checks++;
      if (dt_req !== 32'd10) begin
         errors++;
         $display("FAIL grants_load: got %0d want 10", dt_req);
      end
      step(1, 32'd10, 32'd3);
      checks++;
      if (dt_req !== 32'd7) begin
         errors++;
         $display("FAIL grants_a: got %0d want 7", dt_req);
      end
      step(1, 32'd10, 32'd3);
      checks++;
      if (dt_req !== 32'd4) begin
         errors++;
         $display("FAIL grants_b: got %0d want 4", dt_req);
      end
      step(1, 32'd10, 32'd4);
      checks++;
      if (dt_req !== 32'd10 || clk_val !== 1'b1 || clk_rise !== 1'b1 || dt_err !== 1'b0) begin
         errors++;
         $display("FAIL grants_edge: got req=%0d val=%b rise=%b err=%b, want 10 1 1 0", dt_req, clk_val, clk_rise, dt_err);
      end
      step(1, 32'd10, 32'd0);
      checks++;
      if (dt_req !== 32'd10 || clk_rise !== 1'b0) begin
         errors++;
         $display("FAIL grants_zero: got req=%0d rise=%b, want 10 0", dt_req, clk_rise);
      end
   endtask

   task automatic test_overshoot();
      do_reset();
      step(1, 32'd6, 32'd0);
      step(1, 32'd6, 32'd2);
      checks++;
      if (dt_req !== 32'd4 || dt_err !== 1'b0) begin
         errors++;
         $display("FAIL over_pre: got req=%0d err=%b, want 4 0", dt_req, dt_err);
      end
      step(1, 32'd6, 32'd6);
      checks++;
      if (dt_err !== 1'b1 || clk_val !== 1'b1 || dt_req !== 32'd6) begin
         errors++;
         $display("FAIL over_edge: got err=%b val=%b req=%0d, want 1 1 6", dt_err, clk_val, dt_req);
      end
      for (int k = 0; k < 5; k++) step(k[0], 32'd6, 32'd1);
      checks++;
      if (dt_err !== 1'b1) begin
         errors++;
         $display("FAIL over_sticky: got err=%b want 1", dt_err);
      end
      do_reset();
      checks++;
      if (dt_err !== 1'b0) begin
         errors++;
         $display("FAIL over_clear: got err=%b want 0", dt_err);
      end
   endtask

   task automatic test_stop();
      do_reset();
      step(1, 32'd8, 32'd1);
      for (int k = 0; k < 8; k++) step(1, 32'd8, 32'd1);
      checks++;
      if (clk_val !== 1'b1 || dt_req !== 32'd8) begin
         errors++;
         $display("FAIL stop_pre: got val=%b req=%0d, want 1 8", clk_val, dt_req);
      end
      for (int j = 1; j <= 8; j++) begin
         step(0, 32'd8, 32'd1);
         checks++;
         if (j < 8) begin
            if (clk_val !== 1'b1 || dt_req !== 32'(8 - j) || clk_rise !== 1'b0) begin
               errors++;
               $display("FAIL stop_drain j=%0d: got val=%b req=%0d rise=%b", j, clk_val, dt_req, clk_rise);
            end
         end else begin
            if (clk_val !== 1'b0 || dt_req !== DTM || clk_rise !== 1'b0) begin
               errors++;
               $display("FAIL stop_fall: got val=%b req=%h rise=%b", clk_val, dt_req, clk_rise);
            end
         end
      end
      step(0, 32'd8, 32'd1);
      checks++;
      if (clk_val !== 1'b0 || dt_req !== DTM || clk_rise !== 1'b0) begin
         errors++;
         $display("FAIL stop_idle: got val=%b req=%h rise=%b", clk_val, dt_req, clk_rise);
      end
   endtask

   task automatic test_hp0();
      do_reset();
      step(1, 32'd0, 32'd1);
      checks++;
      if (dt_req !== 32'd1) begin
         errors++;
         $display("FAIL hp0_load: got %0d want 1", dt_req);
      end
      for (int k = 1; k <= 8; k++) begin
         step(1, 32'd0, 32'd1);
         checks++;
         if (clk_val !== k[0] || clk_rise !== k[0] || dt_req !== 32'd1) begin
            errors++;
            $display("FAIL hp0 k=%0d: got val=%b rise=%b req=%0d", k, clk_val, clk_rise, dt_req);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      step(1, 32'd7, 32'd1);
      for (int k = 0; k < 10; k++) step(1, 32'd7, 32'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dt_req !== DTM || clk_val !== 1'b0 || clk_rise !== 1'b0 || dt_err !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: got req=%h val=%b rise=%b err=%b", dt_req, clk_val, clk_rise, dt_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 32'd7, 32'd1);
      n = 0;
      while (clk_rise !== 1'b1 && n < 50) begin
         step(1, 32'd7, 32'd1);
         n++;
      end
      checks++;
      if (n != 7) begin
         errors++;
         $display("FAIL async_restart: rise after %0d grants, want 7", n);
      end
   endtask

   task automatic test_random();
      bit          en;
      logic [31:0] hp;
      logic [31:0] dt;
      int          r;
      do_reset();
      en = 1;
      hp = 32'd4;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 15) == 0) en = !en;
         if ($urandom_range(0, 7) == 0) hp = 32'($urandom_range(0, 12));
         r = $urandom_range(0, 9);
         if (!m_act) dt = 32'($urandom_range(0, 5));
         else if (r == 0) dt = 32'd0;
         else if (r == 1) dt = m_req + 32'($urandom_range(1, 3));
         else if (r <= 4) dt = m_req;
         else dt = 32'($urandom_range(1, int'(m_req)));
         step(en, hp, dt);
         checks++;
         if (dt_req !== m_req || clk_val !== m_lvl || clk_rise !== m_rise || dt_err !== m_err) begin
            errors++;
            $display("FAIL random k=%0d: got req=%h val=%b rise=%b err=%b, want req=%h val=%b rise=%b err=%b",
                     k, dt_req, clk_val, clk_rise, dt_err, m_req, m_lvl, m_rise, m_err);
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      half_period = 32'd5;
      emu_dt      = 32'd0;
      model_reset();
      test_reset();
      test_hp5();
      test_grants();
      test_overshoot();
      test_stop();
      test_hp0();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
